// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared definitions for the bit-serial adder/subtractor.
//   - state_t       : controller states (idle, shifting, done)
//   - DEF_WIDTH     : default operand width
//   - sat_max/min   : signed extreme values for a given width, used when the
//                     saturating build (SERIAL_ADDSUB_SAT_EN) is selected
package serial_addsub_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // 0 followed by ones, right-aligned in 32 bits
   function automatic logic [31:0] sat_max(input int w);
      return (32'h1 << (w - 1)) - 32'h1;
   endfunction

   // 1 followed by zeros, right-aligned in 32 bits
   function automatic logic [31:0] sat_min(input int w);
      return 32'h1 << (w - 1);
   endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: combinational 1-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor. One full-adder
// cell is reused LSB-first, one bit per cycle, with a registered carry.
//   clk, rst_n      : clock, synchronous active-low reset
//   start, sub, a, b: operation request (accepted when ready=1); sub=1 -> a-b
//   ready, busy     : can accept / bits being processed
//   done            : one-cycle pulse, result and flags final
//   result          : sum/difference (partial shift register while busy)
//   carry_out       : final carry (for subtract, 1 = no borrow)
//   overflow        : signed overflow
// Build option: define SERIAL_ADDSUB_SAT_EN to saturate result on overflow.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opa, opb;
   logic             cy;
   logic [CNT_W-1:0] cnt;
   logic             load, last;
   logic             s_bit, c_bit;
   logic [WIDTH-1:0] res_fin, res_out;
   logic             ovf_fin;

   fa_cell u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (cy),
      .sum  (s_bit),
      .cout (c_bit)
   );

   assign last    = (state == S_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
   assign res_fin = {s_bit, result[WIDTH-1:1]};
   // On the MSB cycle cy is the carry into the MSB, c_bit the carry out
   assign ovf_fin = cy ^ c_bit;

`ifdef SERIAL_ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
   // On the last bit opa[0]/opb[0] are the MSBs of A and effective B
   assign res_out = !ovf_fin                ? res_fin :
                    (!opa[0] && !opb[0])    ? SMAX    : SMIN;
`else
   assign res_out = res_fin;
`endif

   assign ready = (state != S_SHIFT);
   assign busy  = (state == S_SHIFT);
   assign done  = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            // back-to-back: a start here skips the idle cycle
            load      = start;
            state_nxt = start ? S_SHIFT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         opa       <= '0;
         opb       <= '0;
         cy        <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            opa <= a;
            opb <= sub ? ~b : b;
            cy  <= sub;        // +1 of the two's-complement negate
            cnt <= '0;
         end else if (state == S_SHIFT) begin
            opa <= opa >> 1;
            opb <= opb >> 1;
            cy  <= c_bit;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
               result    <= res_out;
               carry_out <= c_bit;
               overflow  <= ovf_fin;
            end else begin
               result    <= res_fin;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         ready, busy, done, carry_out, overflow;
   logic [W-1:0] result;

   int total = 0;
   int bad   = 0;
   int lat   = 0;
   bit chk_en = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   function automatic void model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xs, output logic [W-1:0] r,
                                 output logic co, output logic ov);
      int sa, sb, ua, ub, full;
      sa = int'($signed(xa));
      sb = int'($signed(xb));
      ua = int'(xa);
      ub = int'(xb);
      full = xs ? sa - sb : sa + sb;
      co = xs ? (ua >= ub) : (ua + ub > 255);
      ov = (full > 127) || (full < -128);
      r  = full[W-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
      if (ov) r = (full > 0) ? 8'h7F : 8'h80;
`endif
   endfunction

   // Cycle-level expectation: remaining bit cycles, done pulse, held outputs
   int           m_left = 0;
   bit           m_done = 0;
   logic [W-1:0] exp_res = '0, pend_res = '0;
   logic         exp_co = 0, exp_ov = 0, pend_co = 0, pend_ov = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0; m_done = 0;
         exp_res = '0; exp_co = 0; exp_ov = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1;
            exp_res = pend_res; exp_co = pend_co; exp_ov = pend_ov;
         end
      end else begin
         m_done = 0;
         if (start) begin
            model(a, b, sub, pend_res, pend_co, pend_ov);
            m_left = W;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(ready), 32'(m_left == 0));
         chk("busy",  32'(busy),  32'(m_left > 0));
         chk("done",  32'(done),  32'(m_done));
         if (m_left == 0) begin
            chk("result",    32'(result),    32'(exp_res));
            chk("carry_out", 32'(carry_out), 32'(exp_co));
            chk("overflow",  32'(overflow),  32'(exp_ov));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      lat++;
   endtask

   // Called right after a negedge while ready: request for one cycle
   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
      a = xa; b = xb; sub = xs; start = 1'b1;
      lat = 0;
      step();
      start = 1'b0;
      a = $urandom_range(255); b = $urandom_range(255); sub = $urandom_range(1);
   endtask

   task automatic wait_done(input string nm, input logic [W-1:0] er,
                            input logic eco, input logic eov);
      while (!done && lat < 30) step();
      chk({nm, "_timeout"}, 32'(done), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
      chk({nm, "_res"}, 32'(result), 32'(er));
      chk({nm, "_co"},  32'(carry_out), 32'(eco));
      chk({nm, "_ov"},  32'(overflow), 32'(eov));
   endtask

   task automatic no_done(input string nm, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (done) seen++;
      end
      chk(nm, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      step(); step();
      rst_n = 1'b1;
      chk_en = 1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_res",   32'(result), 32'd0);
      step();

      launch(8'h05, 8'h03, 1'b0);
      wait_done("add5_3", 8'h08, 1'b0, 1'b0);
      step();

      launch(8'h03, 8'h05, 1'b1);
      wait_done("sub3_5", 8'hFE, 1'b0, 1'b0);
      step();

      launch(8'h7F, 8'h01, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
      wait_done("add7f_1", 8'h7F, 1'b0, 1'b1);
`else
      wait_done("add7f_1", 8'h80, 1'b0, 1'b1);
`endif
      step();

      launch(8'hFF, 8'h01, 1'b0);
      wait_done("addff_1", 8'h00, 1'b1, 1'b0);
      // start inside the DONE cycle: accepted with no idle cycle between
      launch(8'h80, 8'h01, 1'b1);
      chk("b2b_busy", 32'(busy), 32'd1);
`ifdef SERIAL_ADDSUB_SAT_EN
      wait_done("sub80_1", 8'h80, 1'b1, 1'b1);
`else
      wait_done("sub80_1", 8'h7F, 1'b1, 1'b1);
`endif
      step();

      // start while busy is ignored
      launch(8'h12, 8'h34, 1'b0);
      step(); step();
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("ignored", 8'h46, 1'b0, 1'b0);
      no_done("ignored_no_second", 12);

      // reset mid-operation aborts with no done
      launch(8'h40, 8'h40, 1'b0);
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_res",   32'(result), 32'd0);
      chk("abort_co",    32'(carry_out), 32'd0);
      chk("abort_ov",    32'(overflow), 32'd0);
      no_done("abort_no_done", 12);

      launch(8'h0A, 8'h14, 1'b1);
      wait_done("after_rst", 8'hF6, 1'b0, 1'b0);
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor, the sequential counterpart of the team's combinational full-adder cell.
- A single full-adder cell is reused once per cycle, LSB-first, with a registered carry/borrow.
- Operands are loaded in parallel through a start/ready handshake. The result is returned in parallel with a done pulse.
- Used in area-constrained datapaths where a ripple adder of WIDTH cells is too large.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request to begin an operation; accepted only when ready=1.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high in IDLE and DONE; a new operation may be accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH (see Optional Feature).
- carry_out  output  1  final carry; for subtract, 1 = no borrow (A>=B unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is synchronous and active-low: while rst_n=0 at a rising edge, go to IDLE and clear result, carry_out, overflow, done and busy to 0; ready=1 after the reset edge. Reset mid-operation aborts silently with no done pulse.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: ready=1. On start=1, load:
  - opA = a
  - opB = sub ? ~b : b
  - carry reg = sub
  - count = 0
  - go to SHIFT.
- SHIFT: busy=1, ready=0. Each cycle:
  - Compute sum bit and carry from opA[0], opB[0] and the carry reg.
  - Shift sum into the result MSB (shift right); shift opA and opB right.
  - Update the carry reg; count++.
  - On the cycle processing bit WIDTH-1, also capture carry-in-to-MSB for overflow.
  - When count reaches WIDTH-1, go to DONE.
  - start is ignored in SHIFT; no queueing.
- DONE: done=1 for exactly one cycle; result, carry_out and overflow are final. ready=1. If start=1 in DONE, load the new operands immediately and go to SHIFT, otherwise go to IDLE.
- Latency: start accepted at edge N -> done=1 during the cycle after edge N+WIDTH. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- result, carry_out and overflow hold their values from done until the next accepted start. During SHIFT, result is a partial shift register and must not be used.
- Operands are registered at start; a/b/sub may change freely afterwards.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: at DONE, if overflow=1, result saturates to signed max (0 followed by ones) when the MSBs of A and the effective B were 0, otherwise to signed min (1 followed by zeros). The overflow flag is still reported; carry_out is unchanged.
- Undefined: result wraps modulo 2^WIDTH. No saturation logic is synthesised.

Decomposition:
- Shared package serial_addsub_pkg holds:
  - state enum (S_IDLE, S_SHIFT, S_DONE)
  - localparams for the default WIDTH
  - signed max/min helper functions used by the saturation path.
- One natural sub-module, fa_cell: a combinational 1-bit full adder (a, b, cin -> sum, cout) instantiated once. The top holds all state.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, sub=0, pulse start -> done asserts 9 cycles after the accept edge; result=0x08, carry_out=0, overflow=0.
- a=0x03, b=0x05, sub=1 -> result=0xFE, carry_out=0 (borrow), overflow=0.
- a=0x7F, b=0x01, sub=0 -> result=0x80, overflow=1, carry_out=0. With SERIAL_ADDSUB_SAT_EN defined: result=0x7F, overflow=1.
- a=0xFF, b=0x01, sub=0 -> result=0x00, carry_out=1, overflow=0. Then assert start in the DONE cycle with a=0x80, b=0x01, sub=1 -> new op accepted with no IDLE cycle; result=0x7F, overflow=1 (sat build: 0x80).
- Start op, pulse start again at cycle 3 while busy -> ignored; a single done with the first operation's result.
- Start op, drive rst_n=0 at cycle 4 -> no done; next cycle ready=1, busy=0, result=0, carry_out=0, overflow=0. A subsequent op completes correctly.
